// File: rtl/ex_pkg.sv
// Execute-stage shared definitions.
// Holds ALU op codes, the muldiv FSM encoding and the ID/EX bundle.
package ex_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;
  localparam logic [3:0] ALU_MUL  = 4'd11;
  localparam logic [3:0] ALU_DIVU = 4'd12;
  localparam logic [3:0] ALU_REMU = 4'd13;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic        alusrc;
    logic [31:0] busa;
    logic [31:0] busb;
    logic [31:0] imm;
    logic [31:0] ds2;
    logic        memwr;
    logic        memtoreg;
    logic        regwr;
    logic        loadext;
    logic        jump;
    logic        jal;
    logic [1:0]  dsize;
    logic [1:0]  fpoint;
    logic [4:0]  rw;
  } id_ex_t;

  function automatic logic is_multi(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative 32-step shift-add multiplier / restoring divider.
// Sequenced by an IDLE -> BUSY -> DONE FSM; DONE lasts one cycle.
module muldiv_seq
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [32:0] rem_sh;
  logic        rem_ge;

  // acc: product / partial remainder, x: multiplier / quotient, y: other operand
  assign rem_sh = {acc_q, x_q[31]};
  assign rem_ge = rem_sh >= {1'b0, y_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = 5'd0;
          acc_d   = 32'd0;
          x_d     = a;
          y_d     = b;
        end
      end
      MD_BUSY: begin
        if (op == ALU_MUL) begin
          if (x_q[0]) acc_d = acc_q + y_q;
          y_d = y_q << 1;
          x_d = x_q >> 1;
        end else if (rem_ge) begin
          acc_d = 32'(rem_sh - {1'b0, y_q});
          x_d   = {x_q[30:0], 1'b1};
        end else begin
          acc_d = rem_sh[31:0];
          x_d   = {x_q[30:0], 1'b0};
        end
        cnt_d = 5'(cnt_q + 5'd1);
        if (cnt_q == 5'd31) state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 32'd0;
      x_q     <= 32'd0;
      y_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign done = state_q == MD_DONE;
  assign busy = start && (state_q != MD_DONE);

  always_comb begin
    result = 32'd0;
    case (op)
      ALU_MUL:  result = acc_q;
      ALU_DIVU: result = x_q;
      ALU_REMU: result = acc_q;
      default:  result = 32'd0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: registered ID/EX bundle, single-cycle ALU and
// an iterative mul/div unit that stalls upstream until its result is ready.
module ex_stage
  import ex_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   dALUCtrl,
  input  logic         dALUSrc,
  input  logic [N-1:0] dBusA,
  input  logic [N-1:0] dBusB,
  input  logic [N-1:0] dImm,
  input  logic [N-1:0] dDelayslot2,
  input  logic         dMemWr,
  input  logic         dMemtoReg,
  input  logic         dRegWr,
  input  logic         dloadext,
  input  logic         dJump,
  input  logic         dJal,
  input  logic [1:0]   dDsize,
  input  logic [1:0]   dFPoint,
  input  logic [4:0]   dRw,
  output logic         MemWr,
  output logic         MemtoReg,
  output logic         RegWr,
  output logic         loadext,
  output logic         Jump,
  output logic         Jal,
  output logic [1:0]   Dsize,
  output logic [1:0]   FPoint,
  output logic [4:0]   Rw,
  output logic [N-1:0] ExecResult,
  output logic [N-1:0] BusB,
  output logic [N-1:0] Delayslot2,
  output logic         stall
);

  id_ex_t      in_q, in_d;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic [31:0] md_res;
  logic        md_start;
  logic        md_busy;
  logic        md_done;

  assign in_d = '{
    ctrl: dALUCtrl, alusrc: dALUSrc, busa: dBusA, busb: dBusB,
    imm: dImm, ds2: dDelayslot2, memwr: dMemWr, memtoreg: dMemtoReg,
    regwr: dRegWr, loadext: dloadext, jump: dJump, jal: dJal,
    dsize: dDsize, fpoint: dFPoint, rw: dRw
  };

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       in_q <= '0;
    else if (!stall) in_q <= in_d;
  end

  assign op_b = in_q.alusrc ? in_q.imm : in_q.busb;

  always_comb begin
    alu_res = 32'd0;
    case (in_q.ctrl)
      ALU_ADD:  alu_res = in_q.busa + op_b;
      ALU_SUB:  alu_res = in_q.busa - op_b;
      ALU_AND:  alu_res = in_q.busa & op_b;
      ALU_OR:   alu_res = in_q.busa | op_b;
      ALU_XOR:  alu_res = in_q.busa ^ op_b;
      ALU_SLL:  alu_res = in_q.busa << op_b[4:0];
      ALU_SRL:  alu_res = in_q.busa >> op_b[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(in_q.busa) >>> op_b[4:0]);
      ALU_SLT:  alu_res = {31'd0, $signed(in_q.busa) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'd0, in_q.busa < op_b};
      ALU_LUI:  alu_res = op_b << 16;
      default:  alu_res = 32'd0;
    endcase
  end

  assign md_start = is_multi(in_q.ctrl);

  muldiv_seq u_muldiv (
    .clk    (clk),
    .rst    (reset),
    .start  (md_start),
    .op     (in_q.ctrl),
    .a      (in_q.busa),
    .b      (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_res)
  );

  assign stall = md_busy;

  // Side-effecting controls become a bubble while the result is pending
  assign MemWr      = in_q.memwr & ~stall;
  assign RegWr      = in_q.regwr & ~stall;
  assign Jump       = in_q.jump & ~stall;
  assign Jal        = in_q.jal & ~stall;
  assign MemtoReg   = in_q.memtoreg;
  assign loadext    = in_q.loadext;
  assign Dsize      = in_q.dsize;
  assign FPoint     = in_q.fpoint;
  assign Rw         = in_q.rw;
  assign BusB       = in_q.busb;
  assign Delayslot2 = in_q.ds2;
  assign ExecResult = md_done ? md_res : alu_res;

endmodule

// File: tb/tb_ex_stage.sv
// Directed + randomized bench for ex_stage against an arithmetic reference.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  dALUCtrl;
  logic        dALUSrc;
  logic [31:0] dBusA, dBusB, dImm, dDelayslot2;
  logic        dMemWr, dMemtoReg, dRegWr, dloadext, dJump, dJal;
  logic [1:0]  dDsize, dFPoint;
  logic [4:0]  dRw;
  logic        MemWr, MemtoReg, RegWr, loadext, Jump, Jal;
  logic [1:0]  Dsize, FPoint;
  logic [4:0]  Rw;
  logic [31:0] ExecResult, BusB, Delayslot2;
  logic        stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_stage #(.N(32)) dut (
    .clk(clk), .reset(reset),
    .dALUCtrl(dALUCtrl), .dALUSrc(dALUSrc),
    .dBusA(dBusA), .dBusB(dBusB), .dImm(dImm), .dDelayslot2(dDelayslot2),
    .dMemWr(dMemWr), .dMemtoReg(dMemtoReg), .dRegWr(dRegWr),
    .dloadext(dloadext), .dJump(dJump), .dJal(dJal),
    .dDsize(dDsize), .dFPoint(dFPoint), .dRw(dRw),
    .MemWr(MemWr), .MemtoReg(MemtoReg), .RegWr(RegWr),
    .loadext(loadext), .Jump(Jump), .Jal(Jal),
    .Dsize(Dsize), .FPoint(FPoint), .Rw(Rw),
    .ExecResult(ExecResult), .BusB(BusB), .Delayslot2(Delayslot2),
    .stall(stall)
  );

  function automatic logic [31:0] ref_alu(
    input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return $unsigned($signed(a) >>> sh);
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b * 32'd65536;
      4'd11: begin
        prod = {32'd0, a} * {32'd0, b};
        return prod[31:0];
      end
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm,
                       input logic src, input logic regwr);
    dALUCtrl    = op;
    dALUSrc     = src;
    dBusA       = a;
    dBusB       = b;
    dImm        = imm;
    dDelayslot2 = $urandom;
    dMemWr      = 1'($urandom);
    dMemtoReg   = 1'($urandom);
    dRegWr      = regwr;
    dloadext    = 1'($urandom);
    dJump       = 1'($urandom);
    dJal        = 1'($urandom);
    dDsize      = 2'($urandom);
    dFPoint     = 2'($urandom);
    dRw         = 5'($urandom);
  endtask

  task automatic check_ctrl(input string tag);
    check({tag, "_ctrl"},
      64'({MemWr, MemtoReg, RegWr, loadext, Jump, Jal, Dsize, FPoint, Rw}),
      64'({dMemWr, dMemtoReg, dRegWr, dloadext, dJump, dJal,
           dDsize, dFPoint, dRw}));
    check({tag, "_busb"}, 64'(BusB), 64'(dBusB));
    check({tag, "_ds2"}, 64'(Delayslot2), 64'(dDelayslot2));
  endtask

  task automatic single(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic src);
    drive(op, a, b, imm, src, 1'($urandom));
    @(posedge clk); #1;
    check({tag, "_stall"}, 64'(stall), 64'(0));
    check({tag, "_res"}, 64'(ExecResult),
          64'(ref_alu(op, a, src ? imm : b)));
    check_ctrl(tag);
  endtask

  task automatic multi(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic src);
    int n;
    int bub;
    drive(op, a, b, imm, src, 1'b1);
    @(posedge clk); #1;
    n = 0;
    bub = 0;
    while (stall === 1'b1 && n < 40) begin
      if ({MemWr, RegWr, Jump, Jal} !== 4'b0000) bub++;
      n++;
      @(posedge clk); #1;
    end
    check({tag, "_stallcyc"}, 64'(n), 64'(33));
    check({tag, "_bubble"}, 64'(bub), 64'(0));
    check({tag, "_stall_end"}, 64'(stall), 64'(0));
    check({tag, "_res"}, 64'(ExecResult),
          64'(ref_alu(op, a, src ? imm : b)));
    check_ctrl(tag);
  endtask

  initial begin
    reset = 1'b1;
    drive(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    dDelayslot2 = 32'hDEAD_BEEF;
    dMemWr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_res", 64'(ExecResult), 64'(0));
    check("rst_ctrl",
      64'({MemWr, MemtoReg, RegWr, loadext, Jump, Jal, Dsize, FPoint, Rw}),
      64'(0));
    check("rst_ds2", 64'(Delayslot2), 64'(0));
    reset = 1'b0;

    single("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0);
    single("sra_imm", 4'd7, 32'h8000_0000, 32'h1234_5678, 32'd4, 1'b1);
    check("sra_exact", 64'(ExecResult), 64'(32'hF800_0000));
    single("lui", 4'd10, 32'd0, 32'h0000_ABCD, 32'd0, 1'b0);
    single("slt_neg", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    single("sltu_neg", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    single("op14", 4'd14, 32'h1111_1111, 32'h2222_2222, 32'd0, 1'b0);
    single("op15", 4'd15, 32'h1111_1111, 32'h2222_2222, 32'd0, 1'b0);

    multi("mul", 4'd11, 32'h0001_0003, 32'h0002_0005, 32'd0, 1'b0);
    check("mul_exact", 64'(ExecResult), 64'(32'h000B_000F));
    multi("divu", 4'd12, 32'd100, 32'd7, 32'd0, 1'b0);
    check("divu_exact", 64'(ExecResult), 64'(14));
    multi("remu", 4'd13, 32'd100, 32'd7, 32'd0, 1'b0);
    check("remu_exact", 64'(ExecResult), 64'(2));
    multi("divu0", 4'd12, 32'h1234, 32'd0, 32'd0, 1'b0);
    multi("remu0", 4'd13, 32'h1234, 32'd0, 32'd0, 1'b0);
    multi("mul_imm", 4'd11, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b1);
    single("after_md", 4'd1, 32'd5, 32'd9, 32'd0, 1'b0);

    drive(4'd11, 32'h0001_0003, 32'h0002_0005, 32'd0, 1'b0, 1'b1);
    @(posedge clk);
    repeat (11) @(posedge clk);
    #1;
    check("midbusy_stall", 64'(stall), 64'(1));
    reset = 1'b1;
    #1;
    check("rst_mid_stall", 64'(stall), 64'(0));
    check("rst_mid_res", 64'(ExecResult), 64'(0));
    check("rst_mid_ctrl",
      64'({MemWr, MemtoReg, RegWr, loadext, Jump, Jal, Dsize, FPoint, Rw}),
      64'(0));
    check("rst_mid_bus", {BusB, Delayslot2}, 64'(0));
    #1;
    reset = 1'b0;
    single("add_after_rst", 4'd0, 32'd2, 32'd3, 32'd0, 1'b0);
    check("add_after_rst_exact", 64'(ExecResult), 64'(5));

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 11));
      if (op == 4'd11) op = 4'($urandom_range(14, 15));
      single("rnd_alu", op, $urandom, $urandom, $urandom, 1'($urandom));
    end
    for (int i = 0; i < 6; i++) begin
      logic [31:0] b;
      b = (i % 2 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      multi("rnd_md", 4'($urandom_range(11, 13)), $urandom, b,
            $urandom, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter N, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port dALUCtrl, input, 4, operation code.
REQ-005 SHALL have port dALUSrc, input, 1, operand-B select: 1 = dImm, 0 = dBusB.
REQ-006 SHALL have ports dBusA, dBusB, dImm, dDelayslot2, input, 32 each: operands, immediate and link value.
REQ-007 SHALL have ports dMemWr, dMemtoReg, dRegWr, dloadext, dJump, dJal, input, 1 each: controls passed toward memory.
REQ-008 SHALL have ports dDsize, dFPoint, input, 2 each, and dRw, input, 5: passed toward memory.
REQ-009 SHALL have ports MemWr, MemtoReg, RegWr, loadext, Jump, Jal, Dsize, FPoint, Rw, ExecResult, BusB, Delayslot2, output, with widths matching their d* inputs: they feed the memory stage.
REQ-010 SHALL have port stall, output, 1: high means upstream must hold and must not present a new instruction.

Function
REQ-011 SHALL capture all d* inputs into an input register on the rising edge of clk when stall=0, and SHALL hold that register when stall=1.
REQ-012 SHALL compute outputs from the input register, giving 1-cycle latency for single-cycle ops.
REQ-013 SHALL form operand B as dImm when ALUSrc=1, else BusB; output BusB SHALL always carry the registered raw BusB.
REQ-014 SHALL implement single-cycle ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 LUI (B<<16); shifts SHALL use B[4:0]; add/sub SHALL wrap modulo 2^32.
REQ-015 SHALL implement multi-cycle ops: 11 MUL (low 32 bits of unsigned product), 12 DIVU (quotient), 13 REMU (remainder); codes 14-15 SHALL produce ExecResult=0.
REQ-016 SHALL implement the multi-cycle FSM with states IDLE, BUSY and DONE.
REQ-017 In IDLE with a multi-cycle op registered, the FSM SHALL load its work registers and go to BUSY with count=0.
REQ-018 In BUSY, the FSM SHALL perform one shift-add or restoring-divide step per cycle; at count=31 it SHALL go to DONE; DONE SHALL go to IDLE.
REQ-019 stall SHALL equal (registered op is multi-cycle) AND (state != DONE): 33 stall cycles and 34 cycles of occupancy per multi-cycle op.
REQ-020 While stall=1, outputs MemWr, RegWr, Jump and Jal SHALL be forced to 0 (bubble); other outputs are don't-care.
REQ-021 In DONE, ExecResult SHALL be the multi-cycle result and all controls SHALL be the registered values.
REQ-022 For divisor 0, DIVU SHALL return 0xFFFFFFFF and REMU SHALL return the dividend, both after normal latency.
REQ-023 Back-to-back multi-cycle ops SHALL each start from IDLE; no result SHALL carry over between them.

Reset
REQ-024 On reset, the input register, all outputs, the work registers and count SHALL clear to 0, state SHALL go to IDLE, and stall SHALL go to 0, at any point including mid-BUSY.
REQ-025 After reset deasserts, the first rising edge SHALL capture inputs normally.

Structure
REQ-026 ALU op-code constants and the FSM state encoding SHALL live in shared package ex_pkg.
REQ-027 The iterative multiply/divide datapath SHALL be sub-module muldiv_seq (start, op, a, b -> busy, done, result).

Verification
REQ-028 Scenario: ADD with A=0x7FFFFFFF, B=1 -> ExecResult=0x80000000 one cycle after capture, stall=0.
REQ-029 Scenario: SRA with A=0x80000000, Imm=4, ALUSrc=1 -> ExecResult=0xF8000000; BusB output equals the registered dBusB.
REQ-030 Scenario: MUL with 0x00010003 x 0x00020005, RegWr=1 -> stall high for 33 cycles with RegWr=0 throughout, then one cycle with ExecResult=0x000B000F and RegWr=1.
REQ-031 Scenario: DIVU 100/7 then REMU 100/7 back-to-back -> results 14 then 2, each with 34-cycle occupancy.
REQ-032 Scenario: DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
REQ-033 Scenario: reset asserted at BUSY count=10 -> stall=0 and all outputs 0 immediately; a following ADD 2+3 returns 5 normally.
